// File: rtl/datamem_pkg.sv
// -----------------------------------------------------------------------------
// datamem_pkg
//   Shared types and helpers for the datamem_pipe data memory.
//   - state_t     : controller states (INIT zero-fills the array, RUN serves)
//   - nb_of()     : number of byte lanes for a given data width (NB = DW/8)
//   - byte_parity : even-parity bit for one byte (set so the 9 bits hold an
//                   even number of ones)
// -----------------------------------------------------------------------------
package datamem_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DW_DEFAULT = 16;

  function automatic int nb_of(input int dw);
    return dw / 8;
  endfunction

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/datamem_if.sv
// -----------------------------------------------------------------------------
// datamem_if
//   Request/response bundle between the CPU load/store stage (master) and
//   datamem_pipe (slave).
//   Request : req_valid, req_ready, req_we, req_be[DW/8], req_addr[AW],
//             req_wdata[DW] (+ inj_par when DM_PARITY_EN is defined)
//   Response: rsp_valid, rsp_rdata[DW], rsp_err
// -----------------------------------------------------------------------------
interface datamem_if #(
  parameter int DW = 16,
  parameter int AW = 12
);
  localparam int NB = DW / 8;

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [NB-1:0] req_be;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
`ifdef DM_PARITY_EN
  logic          inj_par;
`endif
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata,
`ifdef DM_PARITY_EN
    output inj_par,
`endif
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata,
`ifdef DM_PARITY_EN
    input  inj_par,
`endif
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/datamem_rdpipe.sv
// -----------------------------------------------------------------------------
// datamem_rdpipe
//   RD_LAT-deep shift pipeline carrying {valid, err, data} from the RAM read
//   to the response ports. Data/err stages only load when the stage feeding
//   them is valid, so the last stage holds the previous response while
//   out_valid is low.
//   Ports: clk, rst (sync, active-high), in_valid/in_err/in_data (RAM side),
//          out_valid/out_err/out_data (response side).
// -----------------------------------------------------------------------------
module datamem_rdpipe #(
  parameter int DW     = 16,
  parameter int RD_LAT = 1   // legal 1..4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_err,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic          out_err,
  output logic [DW-1:0] out_data
);

  logic [RD_LAT-1:0] v;
  logic [RD_LAT-1:0] e;
  logic [DW-1:0]     d [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      // Clearing every valid bit discards reads that are in flight.
      v <= '0;
      e <= '0;
      for (int i = 0; i < RD_LAT; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) begin
        e[0] <= in_err;
        d[0] <= in_data;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) begin
          e[i] <= e[i-1];
          d[i] <= d[i-1];
        end
      end
    end
  end

  assign out_valid = v[RD_LAT-1];
  assign out_err   = e[RD_LAT-1];
  assign out_data  = d[RD_LAT-1];

endmodule

// File: rtl/datamem_pipe.sv
// -----------------------------------------------------------------------------
// datamem_pipe
//   Single-port synchronous data memory with a valid/ready request port,
//   per-byte write enables, out-of-range detection, RD_LAT-cycle reads and a
//   hardware zero-fill (INIT) after every reset.
//   Ports: clk, rst (sync, active-high), bus (datamem_if.slave).
//   Optional: define DM_PARITY_EN to store one even-parity bit per byte;
//   reads flag parity mismatches on rsp_err and bus.inj_par inverts the
//   stored parity of the enabled bytes on an accepted write.
// -----------------------------------------------------------------------------
module datamem_pipe
  import datamem_pkg::*;
#(
  parameter int DW     = DW_DEFAULT,
  parameter int AW     = 12,
  parameter int DEPTH  = 4096,  // <= 2**AW
  parameter int RD_LAT = 1      // 1..4
) (
  input  logic      clk,
  input  logic      rst,
  datamem_if.slave  bus
);

  localparam int NB = nb_of(DW);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_V = (AW + 1)'(DEPTH);
  localparam logic [IW-1:0] LAST_IX = IW'(DEPTH - 1);

  state_t        state, state_nx;
  logic [IW-1:0] init_cnt;
  logic          init_we;
  logic          init_last;
  logic          accept;
  logic          in_range;
  logic          wr_en;
  logic          rd_en;
  logic [IW-1:0] idx;
  logic [DW-1:0] rd_word;
  logic          rd_err;

  logic [DW-1:0] mem [DEPTH];
`ifdef DM_PARITY_EN
  logic [NB-1:0] mem_par [DEPTH];
`endif

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nx;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      INIT:    if (init_last) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = INIT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    init_we       = 1'b0;
    bus.req_ready = 1'b0;
    case (state)
      INIT:    init_we       = 1'b1;
      RUN:     bus.req_ready = 1'b1;
      default: init_we       = 1'b0;
    endcase
  end

  // Zero-fill address; it walks 0..DEPTH-1 once per INIT pass.
  always_ff @(posedge clk) begin
    if (rst)          init_cnt <= '0;
    else if (init_we) init_cnt <= init_cnt + IW'(1);
  end

  assign init_last = (init_cnt == LAST_IX);

  // ---------------- request decode ----------------
  assign idx      = bus.req_addr[IW-1:0];
  assign in_range = ({1'b0, bus.req_addr} < DEPTH_V);
  assign accept   = bus.req_valid & bus.req_ready;
  assign wr_en    = accept & bus.req_we & in_range;   // out-of-range writes drop
  assign rd_en    = accept & ~bus.req_we;

  // ---------------- RAM write port ----------------
  // NOTE: the array has no reset branch; contents are cleared by the INIT
  // walk instead, which keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_cnt] <= '0;
`ifdef DM_PARITY_EN
      mem_par[init_cnt] <= '0;  // even parity of a zero byte is 0
`endif
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.req_be[b]) begin
          mem[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
`ifdef DM_PARITY_EN
          mem_par[idx][b] <= byte_parity(bus.req_wdata[8*b +: 8]) ^ bus.inj_par;
`endif
        end
      end
    end
  end

  // ---------------- RAM read ----------------
  // The read is combinational off the array and registered as stage 0 of the
  // pipeline, so a write accepted one edge earlier is already visible.
  always_comb begin
    rd_word = '0;
    rd_err  = ~in_range;
    if (in_range) begin
      rd_word = mem[idx];
`ifdef DM_PARITY_EN
      for (int b = 0; b < NB; b++) begin
        if (byte_parity(mem[idx][8*b +: 8]) != mem_par[idx][b]) rd_err = 1'b1;
      end
`endif
    end
  end

  datamem_rdpipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_en),
    .in_err    (rd_err),
    .in_data   (rd_word),
    .out_valid (bus.rsp_valid),
    .out_err   (bus.rsp_err),
    .out_data  (bus.rsp_rdata)
  );

endmodule
